cache_mem_master: RTL and testbench

- Initiator-side controller for the main-memory cmd/rsp port; the main-memory model is the responder on the other end.
- Accepts single line-refill (read) or line-writeback (write) requests from the cache controller and drives the memory command channel.
- Collects read data, or detects write completion from the command-ready handshake, and returns a one-cycle completion pulse to the cache.
- Includes a timeout guard so a stalled responder cannot hang the cache.

---
 rtl/cache_mem_master.sv | 159 +++++++++++++++
 tb/tb_cache_mem_master.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_master.sv
// cache_mem_master: single-outstanding line refill/writeback initiator for the main-memory cmd/rsp port.
// Defining CACHE_MEM_MASTER_STATS_EN adds saturating read/write/timeout completion counters.
module cache_mem_master #(
  parameter int ADDR_LEN   = 16,
  parameter int MEMORY_DW  = 256,
  parameter int MEMORY_MW  = 32,
  parameter int OFFSET_LEN = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [MEMORY_DW-1:0] req_wdata,
  input  logic [MEMORY_MW-1:0] req_wmask,
  output logic                 done_valid,
  output logic                 done_err,
  output logic [MEMORY_DW-1:0] done_rdata,
  output logic                 memory_cs,
  output logic                 memory_cmd_valid,
  input  logic                 memory_cmd_ready,
  output logic                 memory_cmd_read,
  output logic [ADDR_LEN-1:0]  memory_cmd_addr,
  output logic [MEMORY_DW-1:0] memory_cmd_wdata,
  output logic [MEMORY_MW-1:0] memory_cmd_wmask,
  input  logic                 memory_rsp_valid,
  output logic                 memory_rsp_ready,
  input  logic [MEMORY_DW-1:0] memory_rsp_rdata
`ifdef CACHE_MEM_MASTER_STATS_EN
  ,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_wr_cnt,
  output logic [15:0]          stat_to_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CMD, RWAIT, WWAIT, DONE} state_t;

  localparam logic [7:0]          TO_LIMIT  = 8'(TIMEOUT);
  localparam logic [ADDR_LEN-1:0] ADDR_MASK = {{(ADDR_LEN-OFFSET_LEN){1'b1}}, {OFFSET_LEN{1'b0}}};

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       seen_busy;
  logic       accept, cmd_hs, rd_ok, wr_ok, to_hit, timed_out, active_nxt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A normal completion takes priority over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmd_hs    = 1'b0;
    rd_ok     = 1'b0;
    wr_ok     = 1'b0;
    to_hit    = 1'b0;
    timed_out = (wait_cnt >= TO_LIMIT);
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        if (memory_cmd_ready) begin
          cmd_hs    = 1'b1;
          state_nxt = memory_cmd_read ? RWAIT : WWAIT;
        end else if (timed_out) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      RWAIT: begin
        if (memory_rsp_valid) begin
          rd_ok     = 1'b1;
          state_nxt = DONE;
        end else if (timed_out) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      WWAIT: begin
        if (seen_busy && memory_cmd_ready) begin
          wr_ok     = 1'b1;
          state_nxt = DONE;
        end else if (timed_out) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt == CMD) || (state_nxt == RWAIT) || (state_nxt == WWAIT);
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_valid       <= 1'b0;
      done_err         <= 1'b0;
      done_rdata       <= '0;
      memory_cs        <= 1'b0;
      memory_cmd_valid <= 1'b0;
      memory_cmd_read  <= 1'b0;
      memory_cmd_addr  <= '0;
      memory_cmd_wdata <= '0;
      memory_cmd_wmask <= '0;
      memory_rsp_ready <= 1'b0;
      seen_busy        <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      done_valid       <= rd_ok | wr_ok | to_hit;
      done_err         <= to_hit;
      memory_cs        <= active_nxt;
      memory_cmd_valid <= (state_nxt == CMD);
      memory_rsp_ready <= (state_nxt == RWAIT);
      if (accept) begin
        memory_cmd_addr  <= req_addr & ADDR_MASK;
        memory_cmd_read  <= ~req_write;
        memory_cmd_wdata <= req_write ? req_wdata : '0;
        memory_cmd_wmask <= req_write ? req_wmask : '0;
      end
      if (rd_ok) done_rdata <= memory_rsp_rdata;
      // Write completion is the responder going busy and then ready again.
      if (cmd_hs)
        seen_busy <= 1'b0;
      else if ((state == WWAIT) && !memory_cmd_ready)
        seen_busy <= 1'b1;
      if (accept)
        wait_cnt <= '0;
      else if ((state == CMD || state == RWAIT || state == WWAIT) && (wait_cnt != 8'hFF))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef CACHE_MEM_MASTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
      stat_to_cnt <= '0;
    end else begin
      if (rd_ok  && (stat_rd_cnt != 16'hFFFF)) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (wr_ok  && (stat_wr_cnt != 16'hFFFF)) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (to_hit && (stat_to_cnt != 16'hFFFF)) stat_to_cnt <= stat_to_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_master.sv
// Testbench for cache_mem_master: randomized requests against a DELAY=2 memory responder and a line-level reference model.
// Stat counter checks are included when CACHE_MEM_MASTER_STATS_EN is defined.
module tb_cache_mem_master;

  localparam int AW    = 16;
  localparam int DW    = 256;
  localparam int MW    = 32;
  localparam int TO    = 20;
  localparam int DELAY = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          done_valid, done_err;
  logic [DW-1:0] done_rdata;
  logic          memory_cs, memory_cmd_valid, memory_cmd_ready, memory_cmd_read;
  logic [AW-1:0] memory_cmd_addr;
  logic [DW-1:0] memory_cmd_wdata;
  logic [MW-1:0] memory_cmd_wmask;
  logic          memory_rsp_valid, memory_rsp_ready;
  logic [DW-1:0] memory_rsp_rdata;
`ifdef CACHE_MEM_MASTER_STATS_EN
  logic [15:0]   stat_rd_cnt, stat_wr_cnt, stat_to_cnt;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            stall_cfg = 0;
  bit            no_rsp = 1'b0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] resp_mem [logic [AW-1:0]];
  logic [DW-1:0] last_rdata = '0;

  cache_mem_master #(
    .ADDR_LEN(AW), .MEMORY_DW(DW), .MEMORY_MW(MW), .OFFSET_LEN(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .done_valid(done_valid), .done_err(done_err), .done_rdata(done_rdata),
    .memory_cs(memory_cs), .memory_cmd_valid(memory_cmd_valid), .memory_cmd_ready(memory_cmd_ready),
    .memory_cmd_read(memory_cmd_read), .memory_cmd_addr(memory_cmd_addr),
    .memory_cmd_wdata(memory_cmd_wdata), .memory_cmd_wmask(memory_cmd_wmask),
    .memory_rsp_valid(memory_rsp_valid), .memory_rsp_ready(memory_rsp_ready),
    .memory_rsp_rdata(memory_rsp_rdata)
`ifdef CACHE_MEM_MASTER_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_to_cnt(stat_to_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] line_init(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++)
      v[i*32 +: 32] = {a, 16'(i)} ^ (32'hA5C30F1E + 32'(i) * 32'h01010101);
    return v;
  endfunction

  function automatic logic [DW-1:0] ref_line(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_init(a);
  endfunction

  function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic [DW-1:0] v;
    v = ref_line(a);
    for (int b = 0; b < MW; b++)
      if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
    ref_mem[a] = v;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory responder: DELAY=2 model, busy for DELAY+1 cycles after each command.
  initial begin
    logic          hs_cmd, hs_rsp, rst_seen, valid_seen, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d, bm, old, rline;
    logic [MW-1:0] m;
    int            busy, vcnt;
    bit            pend;
    busy = 0; vcnt = 0; pend = 1'b0; rline = '0;
    memory_cmd_ready = 1'b1; memory_rsp_valid = 1'b0; memory_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      rst_seen   = rst;
      valid_seen = (memory_cmd_valid === 1'b1);
      hs_cmd     = valid_seen && memory_cmd_ready;
      hs_rsp     = (memory_rsp_valid === 1'b1) && (memory_rsp_ready === 1'b1);
      a = memory_cmd_addr; d = memory_cmd_wdata; m = memory_cmd_wmask; rd = memory_cmd_read;
      @(posedge clk); #1;
      if (rst_seen) begin
        busy = 0; vcnt = 0; pend = 1'b0; memory_rsp_valid = 1'b0;
      end else begin
        if (hs_rsp) begin
          memory_rsp_valid = 1'b0;
          pend = 1'b0;
        end
        if (hs_cmd) begin
          vcnt = 0;
          busy = DELAY + 1;
          old  = resp_mem.exists(a) ? resp_mem[a] : line_init(a);
          if (rd) begin
            pend  = 1'b1;
            rline = old;
          end else begin
            for (int b = 0; b < MW; b++) bm[b*8 +: 8] = {8{m[b]}};
            resp_mem[a] = (old & ~bm) | (d & bm);
          end
        end else begin
          if (valid_seen) vcnt++;
          if (busy > 0) begin
            busy--;
            if (busy == 1 && pend && !no_rsp) begin
              memory_rsp_valid = 1'b1;
              memory_rsp_rdata = rline;
            end
          end
        end
      end
      memory_cmd_ready = (busy == 0) && ((memory_cmd_valid !== 1'b1) || (vcnt >= stall_cfg));
    end
  end

  // Drives one request at a cycle start; returns the accept cycle and the command seen in the next cycle.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m,
                       output int c0, output logic cv, output logic [AW-1:0] ca, output logic cr,
                       output logic [MW-1:0] cm, output logic [DW-1:0] cd);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = rand_line(); req_wmask = $urandom;
    @(negedge clk);
    cv = memory_cmd_valid; ca = memory_cmd_addr; cr = memory_cmd_read; cm = memory_cmd_wmask; cd = memory_cmd_wdata;
  endtask

  // Waits (bounded) for the done pulse; returns its cycle and the cycle-after req_ready/done_valid, ending at a cycle start.
  task automatic wait_done(input int limit, output bit seen, output int dcyc, output logic err,
                           output logic [DW-1:0] rd, output logic [2:0] ctl, output logic av, output logic ar);
    seen = 1'b0; dcyc = -1; err = 1'b0; rd = '0; ctl = '0; av = 1'b1; ar = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        seen = 1'b1; dcyc = cyc; err = done_err; rd = done_rdata;
        ctl = {memory_cs, memory_cmd_valid, memory_rsp_ready};
      end
    end
    if (seen) begin
      @(negedge clk);
      av = done_valid; ar = req_ready;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({done_valid, done_err, memory_cs, memory_cmd_valid, memory_cmd_read, memory_rsp_ready, req_ready} !== 7'b0000001) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: got %b expected 0000001", {done_valid, done_err, memory_cs, memory_cmd_valid, memory_cmd_read, memory_rsp_ready, req_ready});
    end
    vectors++;
    if ({memory_cmd_addr, memory_cmd_wmask} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_mask: got %h/%h expected 0/0", memory_cmd_addr, memory_cmd_wmask);
    end
    vectors++;
    if ((done_rdata | memory_cmd_wdata) !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h/%h expected 0", done_rdata, memory_cmd_wdata);
    end
`ifdef CACHE_MEM_MASTER_STATS_EN
    vectors++;
    if ({stat_rd_cnt, stat_wr_cnt, stat_to_cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", stat_rd_cnt, stat_wr_cnt, stat_to_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = '0;
  endtask

  task automatic test_read_basic();
    int c0, dc; bit seen; logic err, cv, cr, av, ar; logic [AW-1:0] ca; logic [MW-1:0] cm;
    logic [DW-1:0] cd, rd, exp; logic [2:0] ctl;
    exp = ref_line(16'h1234);
    issue(1'b0, 16'h1234, rand_line(), 32'hFFFF_FFFF, c0, cv, ca, cr, cm, cd);
    vectors++;
    if ({cv, cr, ca, cm} !== {1'b1, 1'b1, 16'h1234, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL read_cmd: got v=%b r=%b a=%h m=%h expected v=1 r=1 a=1234 m=0", cv, cr, ca, cm);
    end
    wait_done(20, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || dc !== c0 + 5) begin
      miscompares++;
      $display("[TB] FAIL read_latency: got done at cycle %0d (seen=%0d) expected %0d", dc - c0, seen, 5);
    end
    vectors++;
    if (err !== 1'b0 || rd !== exp) begin
      miscompares++;
      $display("[TB] FAIL read_data: got err=%b %h expected err=0 %h", err, rd, exp);
    end
    vectors++;
    if ({av, ar, ctl} !== 5'b01000) begin
      miscompares++;
      $display("[TB] FAIL read_pulse: got after_valid=%b after_ready=%b ctl=%b expected 0 1 000", av, ar, ctl);
    end
    last_rdata = exp;
  endtask

  task automatic test_write_read();
    int c0, dc; bit seen; logic err, cv, cr, av, ar; logic [AW-1:0] ca; logic [MW-1:0] cm;
    logic [DW-1:0] cd, rd, wd, init; logic [2:0] ctl;
    wd = rand_line();
    init = line_init(16'h0040);
    issue(1'b1, 16'h0040, wd, 32'h0000_000F, c0, cv, ca, cr, cm, cd);
    vectors++;
    if ({cv, cr, ca, cm} !== {1'b1, 1'b0, 16'h0040, 32'h0000_000F} || cd !== wd) begin
      miscompares++;
      $display("[TB] FAIL write_cmd: got v=%b r=%b a=%h m=%h expected v=1 r=0 a=0040 m=0000000f", cv, cr, ca, cm);
    end
    wait_done(20, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || dc !== c0 + 6 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL write_latency: got cycle %0d err=%b (seen=%0d) expected cycle 6 err=0", dc - c0, err, seen);
    end
    vectors++;
    if (rd !== last_rdata || av !== 1'b0 || ar !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL write_hold: got rdata=%h av=%b ar=%b expected rdata=%h av=0 ar=1", rd, av, ar, last_rdata);
    end
    ref_write(16'h0040, wd, 32'h0000_000F);
    issue(1'b0, 16'h0040, '0, '0, c0, cv, ca, cr, cm, cd);
    wait_done(20, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || rd[31:0] !== wd[31:0] || rd[DW-1:32] !== init[DW-1:32]) begin
      miscompares++;
      $display("[TB] FAIL write_readback: got %h expected low word %h over %h", rd, wd[31:0], init);
    end
    if (seen) last_rdata = rd;
  endtask

  task automatic test_backpressure();
    int c0, dc; bit seen; logic err, cv, cr, av, ar; logic [AW-1:0] ca, a; logic [MW-1:0] cm, m;
    logic [DW-1:0] cd, rd, wd; logic [2:0] ctl;
    a = 16'($urandom) & 16'h00FF; wd = rand_line(); m = $urandom;
    stall_cfg = 10;
    issue(1'b1, a, wd, m, c0, cv, ca, cr, cm, cd);
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      vectors++;
      if ({memory_cmd_valid, memory_cs, memory_cmd_read, memory_cmd_addr, memory_cmd_wmask, memory_cmd_wdata}
          !== {1'b1, 1'b1, 1'b0, a & 16'hFFFC, m, wd}) begin
        miscompares++;
        $display("[TB] FAIL bp_stable_c%0d: got v=%b a=%h m=%h expected v=1 a=%h m=%h", k, memory_cmd_valid, memory_cmd_addr, memory_cmd_wmask, a & 16'hFFFC, m);
      end
    end
    stall_cfg = 0;
    wait_done(30, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || dc !== c0 + 16 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_latency: got cycle %0d err=%b (seen=%0d) expected cycle 16 err=0", dc - c0, err, seen);
    end
    ref_write(a & 16'hFFFC, wd, m);
    issue(1'b0, a, '0, '0, c0, cv, ca, cr, cm, cd);
    wait_done(20, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || rd !== ref_line(a & 16'hFFFC)) begin
      miscompares++;
      $display("[TB] FAIL bp_readback: got %h expected %h", rd, ref_line(a & 16'hFFFC));
    end
    if (seen) last_rdata = rd;
  endtask

  task automatic test_timeout();
    int c0, dc; bit seen; logic err, cv, cr, av, ar; logic [AW-1:0] ca; logic [MW-1:0] cm;
    logic [DW-1:0] cd, rd; logic [2:0] ctl;
    no_rsp = 1'b1;
    issue(1'b0, 16'($urandom), '0, '0, c0, cv, ca, cr, cm, cd);
    wait_done(TO + 10, seen, dc, err, rd, ctl, av, ar);
    no_rsp = 1'b0;
    vectors++;
    if (!seen || dc !== c0 + TO + 2 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_latency: got cycle %0d err=%b (seen=%0d) expected cycle %0d err=1", dc - c0, err, seen, TO + 2);
    end
    vectors++;
    if (rd !== last_rdata || ctl !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL timeout_state: got rdata=%h ctl=%b expected rdata=%h ctl=000", rd, ctl, last_rdata);
    end
    vectors++;
    if (av !== 1'b0 || ar !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_after: got done_valid=%b req_ready=%b expected 0 1", av, ar);
    end
  endtask

  task automatic test_reset_mid();
    int c0, dc; bit seen, pulse; logic err, cv, cr, av, ar; logic [AW-1:0] ca, a; logic [MW-1:0] cm;
    logic [DW-1:0] cd, rd; logic [2:0] ctl;
    a = 16'($urandom) & 16'h0FFC;
    issue(1'b0, a, '0, '0, c0, cv, ca, cr, cm, cd);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({done_valid, done_err, memory_cs, memory_cmd_valid, memory_cmd_read, memory_rsp_ready, req_ready} !== 7'b0000001
        || {memory_cmd_addr, memory_cmd_wmask} !== '0 || (done_rdata | memory_cmd_wdata) !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got ctl=%b addr=%h expected ctl=0000001 addr=0",
               {done_valid, done_err, memory_cs, memory_cmd_valid, memory_cmd_read, memory_rsp_ready, req_ready}, memory_cmd_addr);
    end
    pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_valid !== 1'b0) pulse = 1'b1;
    end
    vectors++;
    if (pulse !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done: got done pulse=1 expected 0");
    end
    last_rdata = '0;
    @(posedge clk); #1;
    issue(1'b0, a, '0, '0, c0, cv, ca, cr, cm, cd);
    wait_done(20, seen, dc, err, rd, ctl, av, ar);
    vectors++;
    if (!seen || dc !== c0 + 5 || err !== 1'b0 || rd !== ref_line(a)) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover: got cycle %0d err=%b %h expected cycle 5 err=0 %h", dc - c0, err, rd, ref_line(a));
    end
    if (seen) last_rdata = rd;
  endtask

  task automatic test_random();
    int c0, dc, stall, exp_lat; bit seen, wr; logic err, cv, cr, av, ar; logic [AW-1:0] ca, a, al;
    logic [MW-1:0] cm, m; logic [DW-1:0] cd, rd, wd, exp; logic [2:0] ctl;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = 16'($urandom) & 16'h007F;
      al = a & 16'hFFFC;
      wd = rand_line(); m = $urandom;
      stall = $urandom_range(0, 3);
      stall_cfg = stall;
      exp = wr ? last_rdata : ref_line(al);
      exp_lat = 1 + stall + (wr ? 5 : 4);
      issue(wr, a, wd, m, c0, cv, ca, cr, cm, cd);
      vectors++;
      if ({cv, cr, ca, cm} !== {1'b1, ~wr, al, wr ? m : 32'h0}) begin
        miscompares++;
        $display("[TB] FAIL rand_cmd_%0d: got r=%b a=%h m=%h expected r=%b a=%h m=%h", n, cr, ca, cm, ~wr, al, wr ? m : 32'h0);
      end
      wait_done(30, seen, dc, err, rd, ctl, av, ar);
      stall_cfg = 0;
      vectors++;
      if (!seen || dc !== c0 + exp_lat || err !== 1'b0 || av !== 1'b0 || ar !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand_timing_%0d: got cycle %0d err=%b av=%b ar=%b expected cycle %0d err=0 av=0 ar=1", n, dc - c0, err, av, ar, exp_lat);
      end
      vectors++;
      if (rd !== exp) begin
        miscompares++;
        $display("[TB] FAIL rand_data_%0d: got %h expected %h", n, rd, exp);
      end
      if (wr) ref_write(al, wd, m);
      else last_rdata = exp;
    end
  endtask

`ifdef CACHE_MEM_MASTER_STATS_EN
  task automatic test_stats();
    int c0, dc; bit seen, wr, tmo; logic err, cv, cr, av, ar; logic [AW-1:0] ca, a; logic [MW-1:0] cm, m;
    logic [DW-1:0] cd, rd, wd; logic [2:0] ctl;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = '0;
    for (int n = 0; n < 6; n++) begin
      wr = (n == 3) || (n == 4);
      tmo = (n == 5);
      a = 16'($urandom) & 16'h00FC;
      wd = rand_line(); m = $urandom;
      no_rsp = tmo;
      issue(wr, a, wd, m, c0, cv, ca, cr, cm, cd);
      wait_done(TO + 10, seen, dc, err, rd, ctl, av, ar);
      no_rsp = 1'b0;
      vectors++;
      if (!seen || err !== tmo) begin
        miscompares++;
        $display("[TB] FAIL stats_txn_%0d: got seen=%0d err=%b expected seen=1 err=%b", n, seen, err, tmo);
      end
      if (wr) ref_write(a, wd, m);
    end
    vectors++;
    if ({stat_rd_cnt, stat_wr_cnt, stat_to_cnt} !== {16'd3, 16'd2, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL stats_counts: got %0d/%0d/%0d expected 3/2/1", stat_rd_cnt, stat_wr_cnt, stat_to_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef CACHE_MEM_MASTER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
